// File: rtl/ipsmacge_ifddioout_mm.sv
// rtl/ipsmacge_ifddioout_mm.sv - multi-mode GE transmit output stage (GMII / RGMII-1000 / RGMII-10/100)
// Optional: IPSMACGE_IFDDIOOUT_UNDERRUN_EN adds frame tracking and underrun fill with a sticky flag.
module ipsmacge_ifddioout_mm #(
  parameter int PIPE  = 1,
  parameter int QUIET = 4
) (
  input  logic       txclk,
  input  logic       txrst,
  input  logic [1:0] imode,
  input  logic       ivld,
  input  logic [7:0] idat,
  input  logic       ien,
  input  logic       ier,
  output logic       ordy,
  output logic [7:0] odat_h,
  output logic [7:0] odat_l,
  output logic       octl_h,
  output logic       octl_l,
  output logic [1:0] ocurmode,
  output logic       omodechg,
  output logic       ounderrun
);

  localparam logic [1:0] MODE_GMII  = 2'b00;
  localparam logic [1:0] MODE_R1000 = 2'b01;
  localparam logic [1:0] MODE_R100  = 2'b10;
  localparam logic [1:0] MODE_RSV   = 2'b11;

  typedef enum logic {NIB_LO, NIB_HI} nib_e;

  typedef struct packed {
    logic [7:0] dh;
    logic [7:0] dl;
    logic       ch;
    logic       cl;
  } word_t;

  logic [1:0] mode_q;
  nib_e       nib_q;
  logic [3:0] hi_nib_q;
  logic       hi_ch_q;
  logic       hi_cl_q;
  logic [3:0] quiet_q;
  logic       modechg_q;
  word_t      pipe_q [PIPE];

  logic  accept;
  logic  ur_slot;
  logic  apply;
  word_t word_d;

  // HI is only ever entered from the nibble flow, so LO alone gates acceptance.
  assign ordy   = ~txrst & (nib_q == NIB_LO);
  assign accept = ivld & ordy;
  assign apply  = (imode != mode_q) && (imode != MODE_RSV) &&
                  (quiet_q >= 4'(QUIET)) && (nib_q == NIB_LO);

`ifdef IPSMACGE_IFDDIOOUT_UNDERRUN_EN
  logic frame_q;
  logic underrun_q;

  assign ur_slot   = frame_q & ordy & ~ivld;
  assign ounderrun = underrun_q;

  always_ff @(posedge txclk) begin
    if (txrst) begin
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else if (accept) begin
      if (ien && !frame_q) underrun_q <= 1'b0;
      frame_q <= ien;
    end else if (ur_slot) begin
      underrun_q <= 1'b1;
    end
  end
`else
  assign ur_slot   = 1'b0;
  assign ounderrun = 1'b0;
`endif

  always_comb begin
    word_d = '0;
    if (nib_q == NIB_HI) begin
      word_d = '{dh: {4'h0, hi_nib_q}, dl: {4'h0, hi_nib_q}, ch: hi_ch_q, cl: hi_cl_q};
    end else if (accept) begin
      case (mode_q)
        MODE_GMII:  word_d = '{dh: idat, dl: idat, ch: ien, cl: ier};
        MODE_R1000: word_d = '{dh: {4'h0, idat[3:0]}, dl: {4'h0, idat[7:4]}, ch: ien, cl: ien ^ ier};
        MODE_R100:  word_d = '{dh: {4'h0, idat[3:0]}, dl: {4'h0, idat[3:0]}, ch: ien, cl: ien ^ ier};
        default:    word_d = '0;
      endcase
    end else if (ur_slot) begin
      // Fill slot is data 0 with en=1/er=1; the RGMII control encoding folds that to octl_l=0.
      word_d = '{dh: 8'h00, dl: 8'h00, ch: 1'b1, cl: (mode_q == MODE_GMII)};
    end
  end

  always_ff @(posedge txclk) begin
    if (txrst) begin
      mode_q    <= MODE_GMII;
      nib_q     <= NIB_LO;
      hi_nib_q  <= 4'h0;
      hi_ch_q   <= 1'b0;
      hi_cl_q   <= 1'b0;
      quiet_q   <= 4'h0;
      modechg_q <= 1'b0;
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
    end else begin
      modechg_q <= apply;
      if (apply) mode_q <= imode;

      // A byte accepted on the apply cycle still finishes its high nibble.
      if (nib_q == NIB_HI) begin
        nib_q <= NIB_LO;
      end else if (accept && mode_q == MODE_R100) begin
        nib_q    <= NIB_HI;
        hi_nib_q <= idat[7:4];
        hi_ch_q  <= ien;
        hi_cl_q  <= ien ^ ier;
      end

      if (accept && ien) begin
        quiet_q <= 4'h0;
      end else if (nib_q == NIB_LO && quiet_q != 4'hF) begin
        quiet_q <= quiet_q + 4'h1;
      end

      pipe_q[0] <= word_d;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign odat_h   = pipe_q[PIPE-1].dh;
  assign odat_l   = pipe_q[PIPE-1].dl;
  assign octl_h   = pipe_q[PIPE-1].ch;
  assign octl_l   = pipe_q[PIPE-1].cl;
  assign ocurmode = mode_q;
  assign omodechg = modechg_q;

endmodule

// File: tb/tb_ipsmacge_ifddioout_mm.sv
// tb/tb_ipsmacge_ifddioout_mm.sv - scoreboard bench with a queue-based reference model of the output stage
module tb_ipsmacge_ifddioout_mm;

  localparam int PIPE_P  = 2;
  localparam int QUIET_P = 3;

  typedef struct packed {
    logic [7:0] dh;
    logic [7:0] dl;
    logic       ch;
    logic       cl;
  } word_t;

  typedef struct packed {
    logic [1:0] mode;
    logic       chg;
    logic       ur;
    logic       lo;
  } status_t;

  logic       txclk;
  logic       txrst;
  logic [1:0] imode;
  logic       ivld;
  logic [7:0] idat;
  logic       ien;
  logic       ier;
  logic       ordy;
  logic [7:0] odat_h;
  logic [7:0] odat_l;
  logic       octl_h;
  logic       octl_l;
  logic [1:0] ocurmode;
  logic       omodechg;
  logic       ounderrun;

  ipsmacge_ifddioout_mm #(.PIPE(PIPE_P), .QUIET(QUIET_P)) dut (
    .txclk(txclk), .txrst(txrst), .imode(imode), .ivld(ivld), .idat(idat),
    .ien(ien), .ier(ier), .ordy(ordy), .odat_h(odat_h), .odat_l(odat_l),
    .octl_h(octl_h), .octl_l(octl_l), .ocurmode(ocurmode), .omodechg(omodechg),
    .ounderrun(ounderrun)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  int n_checks = 0;
  int n_err    = 0;

  word_t   exp_q[$];
  status_t st_q[$];

  // Reference model state: applied mode, queued high-nibble words, quiet run length, frame/underrun.
  logic [1:0] m_mode  = 2'b00;
  word_t      m_defer[$];
  int         m_idle  = 0;
  bit         m_frame = 0;
  bit         m_ur    = 0;
  logic [1:0] req     = 2'b00;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    word_t   w;
    status_t s;
    forever begin
      @(posedge txclk);
      #1;
      if (exp_q.size() == 0 || st_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scoreboard_empty actual=%0d required=nonzero", exp_q.size());
      end else begin
        w = exp_q.pop_front();
        s = st_q.pop_front();
        chk("odat_h", odat_h, w.dh);
        chk("odat_l", odat_l, w.dl);
        chk("octl_h", 8'(octl_h), 8'(w.ch));
        chk("octl_l", 8'(octl_l), 8'(w.cl));
        chk("ocurmode", 8'(ocurmode), 8'(s.mode));
        chk("omodechg", 8'(omodechg), 8'(s.chg));
        chk("ounderrun", 8'(ounderrun), 8'(s.ur));
        chk("ordy", 8'(ordy), 8'(!txrst && s.lo));
      end
    end
  end

  task automatic drive(input bit rst, input logic [1:0] md, input bit vld, input logic [7:0] d,
                       input bit en, input bit er, output bit acc);
    word_t   w;
    status_t s;
    bit      lo;
    bit      apply;
    txrst = rst; imode = md; ivld = vld; idat = d; ien = en; ier = er;
    w   = '0;
    acc = 0;
    if (rst) begin
      m_mode = 2'b00; m_defer.delete(); m_idle = 0; m_frame = 0; m_ur = 0;
      exp_q.delete();
      for (int i = 0; i < PIPE_P; i++) exp_q.push_back('0);
      s = '{mode: 2'b00, chg: 1'b0, ur: 1'b0, lo: 1'b1};
      st_q.push_back(s);
    end else begin
      lo  = (m_defer.size() == 0);
      acc = vld && lo;
      if (!lo) begin
        w = m_defer.pop_front();
      end else if (acc) begin
        if (m_mode == 2'b00) w = '{dh: d, dl: d, ch: en, cl: er};
        else if (m_mode == 2'b01) w = '{dh: {4'h0, d[3:0]}, dl: {4'h0, d[7:4]}, ch: en, cl: en ^ er};
        else begin
          w = '{dh: {4'h0, d[3:0]}, dl: {4'h0, d[3:0]}, ch: en, cl: en ^ er};
          m_defer.push_back('{dh: {4'h0, d[7:4]}, dl: {4'h0, d[7:4]}, ch: en, cl: en ^ er});
        end
      end
`ifdef IPSMACGE_IFDDIOOUT_UNDERRUN_EN
      else if (m_frame) begin
        w = '{dh: 8'h00, dl: 8'h00, ch: 1'b1, cl: (m_mode == 2'b00)};
        m_ur = 1;
      end
      if (acc) begin
        if (en && !m_frame) m_ur = 0;
        m_frame = en;
      end
`endif
      apply = (md != m_mode) && (md != 2'b11) && (m_idle >= QUIET_P) && lo;
      if (acc && en) m_idle = 0;
      else if (lo && m_idle < 15) m_idle++;
      if (apply) m_mode = md;
      exp_q.push_back(w);
      s = '{mode: m_mode, chg: apply, ur: m_ur, lo: (m_defer.size() == 0)};
      st_q.push_back(s);
    end
    @(posedge txclk);
    #2;
  endtask

  task automatic idle_n(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(0, req, 0, 8'h00, 0, 0, a);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit en, input bit er);
    bit a;
    a = 0;
    for (int t = 0; t < 4 && !a; t++) drive(0, req, 1, d, en, er, a);
  endtask

  initial begin : driver
    bit a;
    int r;
    int len;
    for (int i = 0; i < PIPE_P - 1; i++) exp_q.push_back('0);
    for (int i = 0; i < 3; i++) drive(1, 2'b00, 0, 8'h00, 0, 0, a);

    send_byte(8'h55, 1, 0);
    send_byte(8'h12, 1, 0);
    drive(0, req, 0, 8'h00, 0, 0, a);
    send_byte(8'h34, 1, 0);
    send_byte(8'h00, 0, 0);
    req = 2'b01;
    send_byte(8'h66, 1, 0);
    send_byte(8'h77, 1, 0);
    idle_n(QUIET_P + 3);
    send_byte(8'hD5, 1, 1);
    send_byte(8'h00, 0, 0);
    req = 2'b10;
    idle_n(QUIET_P + 3);
    drive(0, req, 1, 8'hA5, 1, 0, a);
    drive(0, req, 1, 8'h3C, 1, 0, a);
    drive(0, req, 1, 8'h3C, 1, 0, a);
    drive(0, req, 1, 8'h3C, 1, 0, a);
    send_byte(8'h00, 0, 0);
    req = 2'b11;
    idle_n(QUIET_P + 3);
    req = 2'b10;
    drive(0, req, 1, 8'h7E, 1, 1, a);
    drive(1, req, 1, 8'h00, 0, 0, a);
    drive(1, req, 1, 8'h00, 0, 0, a);
    idle_n(QUIET_P + 2);

    for (int seg = 0; seg < 160; seg++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) drive(1, req, 1'($urandom_range(0, 1)), 8'($urandom), 0, 0, a);
      end else if (r <= 4) begin
        req = 2'($urandom_range(0, 3));
      end else if (r <= 12) begin
        len = $urandom_range(2, 10);
        for (int i = 0; i < len; i++)
          drive(0, req, ($urandom_range(0, 7) != 0), 8'($urandom), 1, ($urandom_range(0, 15) == 0), a);
      end else begin
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++)
          drive(0, req, 1'($urandom_range(0, 1)), 8'($urandom), 0, 1'($urandom_range(0, 1)), a);
      end
    end

    idle_n(PIPE_P + 3);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
